// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory address and IF/ID register.
// Optional perf counters (fetch_count, stall_count) are built only when FETCH_PERF_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] im_address,
  input  logic [31:0] im_instruction,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] r_pc;
  logic [31:0] r_if_id_instruction;
  logic [31:0] r_if_id_pc_plus4;
  logic        r_if_id_valid;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_target;
  logic        w_unused_rpc_lo;

  assign w_pc_plus4        = r_pc + 32'd4;
  assign w_redirect_target = {redirect_pc[31:2], 2'b00};
  // Target is word aligned by construction; the low byte-offset bits are dropped.
  assign w_unused_rpc_lo   = ^redirect_pc[1:0];

  // Stall dominates redirect: the hazard unit re-issues the redirect afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC_ALIGNED;
    end else if (!stall) begin
      r_pc <= redirect ? w_redirect_target : w_pc_plus4;
    end
  end

  // Flush dominates stall so a squashed slot never survives a held cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_id_instruction <= 32'h0;
      r_if_id_pc_plus4    <= 32'h0;
      r_if_id_valid       <= 1'b0;
    end else if (flush) begin
      r_if_id_instruction <= 32'h0;
      r_if_id_pc_plus4    <= 32'h0;
      r_if_id_valid       <= 1'b0;
    end else if (!stall) begin
      r_if_id_instruction <= im_instruction;
      r_if_id_pc_plus4    <= w_pc_plus4;
      r_if_id_valid       <= 1'b1;
    end
  end

  assign im_address        = r_pc;
  assign if_id_instruction = r_if_id_instruction;
  assign if_id_pc_plus4    = r_if_id_pc_plus4;
  assign if_id_valid       = r_if_id_valid;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= 32'h0;
      r_stall_count <= 32'h0;
    end else begin
      if (!flush && !stall) r_fetch_count <= r_fetch_count + 32'd1;
      if (stall)            r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table of per-edge controls and expected state,
// plus hand-written reset sequences.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] im_address;
  logic [31:0] im_instruction;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [64];

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall             (stall),
    .flush             (flush),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .im_address        (im_address),
    .im_instruction    (im_instruction),
    .if_id_instruction (if_id_instruction),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_valid       (if_id_valid)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count       (fetch_count),
    .stall_count       (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign im_instruction = mem[im_address[7:2]];

  typedef struct {
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] pc4;
    logic        v;
    int          fc;
    int          sc;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(logic s, logic f, logic r, logic [31:0] rpc, logic [31:0] pc,
                              logic [31:0] ins, logic [31:0] pc4, logic v, int fc, int sc);
    vec_t x;
    x.stall = s; x.flush = f; x.redirect = r; x.rpc = rpc;
    x.pc = pc; x.ins = ins; x.pc4 = pc4; x.v = v; x.fc = fc; x.sc = sc;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] pc4, input logic v);
    chk({tag, " im_address"}, im_address, pc);
    chk({tag, " if_id_instruction"}, if_id_instruction, ins);
    chk({tag, " if_id_pc_plus4"}, if_id_pc_plus4, pc4);
    chk({tag, " if_id_valid"}, {31'h0, if_id_valid}, {31'h0, v});
  endtask

  task automatic chk_perf(input string tag, input int fc, input int sc);
`ifdef FETCH_PERF_EN
    chk({tag, " fetch_count"}, fetch_count, fc);
    chk({tag, " stall_count"}, stall_count, sc);
`endif
  endtask

  task automatic idle_inputs();
    stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
  endtask

  initial begin
    mem[0] = 32'h2008_0005;
    for (int i = 1; i < 64; i++) mem[i] = 32'h2409_0000 + i;

    // Per-edge controls and expected post-edge state, starting right after reset release.
    vt[0]  = mk(0, 0, 0, 32'h0,          32'h04,         mem[0],  32'h04, 1, 1, 0);
    vt[1]  = mk(0, 0, 0, 32'h0,          32'h08,         mem[1],  32'h08, 1, 2, 0);
    vt[2]  = mk(1, 0, 0, 32'h0,          32'h08,         mem[1],  32'h08, 1, 2, 1);
    vt[3]  = mk(1, 0, 0, 32'h0,          32'h08,         mem[1],  32'h08, 1, 2, 2);
    vt[4]  = mk(0, 0, 0, 32'h0,          32'h0C,         mem[2],  32'h0C, 1, 3, 2);
    vt[5]  = mk(0, 1, 1, 32'h22,         32'h20,         32'h0,   32'h00, 0, 3, 2);
    vt[6]  = mk(0, 0, 0, 32'h0,          32'h24,         mem[8],  32'h24, 1, 4, 2);
    vt[7]  = mk(1, 0, 1, 32'h40,         32'h24,         mem[8],  32'h24, 1, 4, 3);
    vt[8]  = mk(0, 0, 0, 32'h0,          32'h28,         mem[9],  32'h28, 1, 5, 3);
    vt[9]  = mk(1, 1, 0, 32'h0,          32'h28,         32'h0,   32'h00, 0, 5, 4);
    vt[10] = mk(0, 0, 1, 32'h13,         32'h10,         mem[10], 32'h2C, 1, 6, 4);
    vt[11] = mk(0, 0, 0, 32'h0,          32'h14,         mem[4],  32'h14, 1, 7, 4);
    vt[12] = mk(0, 1, 0, 32'h0,          32'h18,         32'h0,   32'h00, 0, 7, 4);
    vt[13] = mk(0, 0, 1, 32'hFFFF_FFFF,  32'hFFFF_FFFC,  mem[6],  32'h1C, 1, 8, 4);
    vt[14] = mk(0, 0, 0, 32'h0,          32'h00,         mem[63], 32'h00, 1, 9, 4);

    // Reset held with junk controls pending.
    rst_n = 1'b0;
    stall = 1'b1; flush = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0080;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    chk_perf("reset", 0, 0);

    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      stall = vt[i].stall; flush = vt[i].flush;
      redirect = vt[i].redirect; redirect_pc = vt[i].rpc;
      @(posedge clk);
      #1;
      chk_state($sformatf("vec%0d", i), vt[i].pc, vt[i].ins, vt[i].pc4, vt[i].v);
      chk_perf($sformatf("vec%0d", i), vt[i].fc, vt[i].sc);
    end

    // Run forward to pc = 16, then drop reset between edges.
    idle_inputs();
    repeat (4) @(posedge clk);
    #1;
    chk("pre-async im_address", im_address, 32'h10);
    @(negedge clk);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0100;
    rst_n = 1'b0;
    #1;
    chk_state("async reset", 32'h0, 32'h0, 32'h0, 1'b0);
    chk_perf("async reset", 0, 0);

    // Pending controls are discarded; release gives a clean first fetch.
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_state("refetch", 32'h04, mem[0], 32'h04, 1'b1);
    chk_perf("refetch", 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
